// File: rtl/kf8255_peer_pkg.sv
// Shared types and constants for the KF8255 mode-1 handshake peer.
package kf8255_peer_pkg;

  typedef enum logic [2:0] {
    PIdle,
    PSetup,
    PStrobe,
    PWaitSet,
    PWaitClr
  } producer_state_t;

  typedef enum logic [1:0] {
    CIdle,
    CAck,
    CWaitObf
  } consumer_state_t;

  localparam logic STB_ACTIVE = 1'b0;
  localparam logic ACK_ACTIVE = 1'b0;

  function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/kf8255_peer_fifo.sv
// Synchronous FIFO with first-word-fall-through head; Depth must be a power of two.
module kf8255_peer_fifo #(
  parameter int unsigned Depth = 4,
  parameter int unsigned Width = 8
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       push_i,
  input  logic [Width-1:0]           data_i,
  input  logic                       pop_i,
  output logic [Width-1:0]           data_o,
  output logic [$clog2(Depth):0]     level_o,
  output logic                       full_o,
  output logic                       empty_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned LvlW = PtrW + 1;

  logic [Width-1:0] mem_q [Depth];
  logic [Width-1:0] mem_d [Depth];
  logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
  logic [LvlW-1:0]  count_q, count_d;
  logic             do_push, do_pop;

  assign full_o  = (count_q == LvlW'(Depth));
  assign empty_o = (count_q == '0);
  assign level_o = count_q;
  assign data_o  = mem_q[rd_ptr_q];
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;

  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (do_push) begin
      mem_d[wr_ptr_q] = data_i;
      wr_ptr_d        = wr_ptr_q + 1'b1;
    end
    if (do_pop) begin
      rd_ptr_d = rd_ptr_q + 1'b1;
    end
    if (do_push && !do_pop) begin
      count_d = count_q + 1'b1;
    end else if (do_pop && !do_push) begin
      count_d = count_q - 1'b1;
    end
  end

  // Storage is not reset; the pointers alone define what is valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: rtl/kf8255_mode1_peer.sv
// Device-side mode-1 partner for a KF8255: strobes bytes into a PPI input port
// and acknowledges bytes out of a PPI output port.
module kf8255_mode1_peer #(
  parameter int unsigned TX_DEPTH       = 4,
  parameter int unsigned SETUP_CYCLES   = 2,
  parameter int unsigned STB_CYCLES     = 3,
  parameter int unsigned ACK_CYCLES     = 3,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic [7:0]                tx_data,
  input  logic                      tx_valid,
  output logic                      tx_ready,
  output logic [$clog2(TX_DEPTH):0] tx_level,
  output logic [7:0]                ppi_in_data,
  output logic                      stb_n,
  input  logic                      ibf,
  input  logic [7:0]                ppi_out_data,
  input  logic                      obf_n,
  output logic                      ack_n,
  output logic [7:0]                rx_data,
  output logic                      rx_valid,
  input  logic                      rx_ready,
  output logic                      timeout
);

  import kf8255_peer_pkg::*;

  localparam int unsigned CntMax = max_u(max_u(SETUP_CYCLES, STB_CYCLES),
                                         max_u(ACK_CYCLES, TIMEOUT_CYCLES));
  localparam int unsigned CntW   = $clog2(CntMax + 1);

  producer_state_t p_state_q, p_state_d;
  consumer_state_t c_state_q, c_state_d;
  logic [CntW-1:0] p_cnt_q, p_cnt_d;
  logic [CntW-1:0] c_cnt_q, c_cnt_d;
  logic            stb_n_q, stb_n_d;
  logic            ack_n_q, ack_n_d;
  logic [7:0]      ppi_in_data_q, ppi_in_data_d;
  logic [7:0]      rx_data_q, rx_data_d;
  logic            rx_valid_q, rx_valid_d;
  logic            timeout_q, timeout_d;
  logic            p_timeout, c_timeout;

  logic [7:0] fifo_head;
  logic       fifo_full, fifo_empty, fifo_pop;

  assign tx_ready = !fifo_full;

  kf8255_peer_fifo #(
    .Depth (TX_DEPTH),
    .Width (8)
  ) u_fifo (
    .clk_i   (clock),
    .rst_i   (reset),
    .push_i  (tx_valid && tx_ready),
    .data_i  (tx_data),
    .pop_i   (fifo_pop),
    .data_o  (fifo_head),
    .level_o (tx_level),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Producer: pop, settle data, strobe, then follow IBF through set and clear.
  always_comb begin
    p_state_d     = p_state_q;
    p_cnt_d       = p_cnt_q;
    ppi_in_data_d = ppi_in_data_q;
    fifo_pop      = 1'b0;
    p_timeout     = 1'b0;
    unique case (p_state_q)
      PIdle: begin
        if (!fifo_empty && !ibf) begin
          fifo_pop      = 1'b1;
          ppi_in_data_d = fifo_head;
          p_state_d     = PSetup;
          p_cnt_d       = '0;
        end
      end
      PSetup: begin
        if (p_cnt_q == CntW'(SETUP_CYCLES - 1)) begin
          p_state_d = PStrobe;
          p_cnt_d   = '0;
        end else begin
          p_cnt_d = p_cnt_q + 1'b1;
        end
      end
      PStrobe: begin
        if (p_cnt_q == CntW'(STB_CYCLES - 1)) begin
          p_state_d = PWaitSet;
          p_cnt_d   = '0;
        end else begin
          p_cnt_d = p_cnt_q + 1'b1;
        end
      end
      PWaitSet, PWaitClr: begin
        if ((p_state_q == PWaitSet) ? ibf : !ibf) begin
          p_state_d = (p_state_q == PWaitSet) ? PWaitClr : PIdle;
          p_cnt_d   = '0;
        end else if (p_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          p_timeout = 1'b1;
          p_state_d = PIdle;
          p_cnt_d   = '0;
        end else begin
          p_cnt_d = p_cnt_q + 1'b1;
        end
      end
      default: begin
        p_state_d = PIdle;
        p_cnt_d   = '0;
      end
    endcase
    stb_n_d = (p_state_d == PStrobe) ? STB_ACTIVE : ~STB_ACTIVE;
  end

  // Consumer: an unread rx byte holds off the next ACK, so the PPI keeps OBF# low.
  always_comb begin
    c_state_d  = c_state_q;
    c_cnt_d    = c_cnt_q;
    rx_data_d  = rx_data_q;
    rx_valid_d = rx_valid_q;
    c_timeout  = 1'b0;
    if (rx_valid_q && rx_ready) begin
      rx_valid_d = 1'b0;
    end
    unique case (c_state_q)
      CIdle: begin
        if (!obf_n && !rx_valid_q) begin
          c_state_d = CAck;
          c_cnt_d   = '0;
        end
      end
      CAck: begin
        if (c_cnt_q == CntW'(ACK_CYCLES - 1)) begin
          rx_data_d  = ppi_out_data;
          rx_valid_d = 1'b1;
          c_state_d  = CWaitObf;
          c_cnt_d    = '0;
        end else begin
          c_cnt_d = c_cnt_q + 1'b1;
        end
      end
      CWaitObf: begin
        if (obf_n) begin
          c_state_d = CIdle;
          c_cnt_d   = '0;
        end else if (c_cnt_q == CntW'(TIMEOUT_CYCLES - 1)) begin
          c_timeout = 1'b1;
          c_state_d = CIdle;
          c_cnt_d   = '0;
        end else begin
          c_cnt_d = c_cnt_q + 1'b1;
        end
      end
      default: begin
        c_state_d = CIdle;
        c_cnt_d   = '0;
      end
    endcase
    ack_n_d   = (c_state_d == CAck) ? ACK_ACTIVE : ~ACK_ACTIVE;
    timeout_d = p_timeout || c_timeout;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      p_state_q     <= PIdle;
      c_state_q     <= CIdle;
      p_cnt_q       <= '0;
      c_cnt_q       <= '0;
      stb_n_q       <= ~STB_ACTIVE;
      ack_n_q       <= ~ACK_ACTIVE;
      ppi_in_data_q <= '0;
      rx_data_q     <= '0;
      rx_valid_q    <= 1'b0;
      timeout_q     <= 1'b0;
    end else begin
      p_state_q     <= p_state_d;
      c_state_q     <= c_state_d;
      p_cnt_q       <= p_cnt_d;
      c_cnt_q       <= c_cnt_d;
      stb_n_q       <= stb_n_d;
      ack_n_q       <= ack_n_d;
      ppi_in_data_q <= ppi_in_data_d;
      rx_data_q     <= rx_data_d;
      rx_valid_q    <= rx_valid_d;
      timeout_q     <= timeout_d;
    end
  end

  assign stb_n       = stb_n_q;
  assign ack_n       = ack_n_q;
  assign ppi_in_data = ppi_in_data_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign timeout     = timeout_q;

endmodule

// File: tb/tb_kf8255_mode1_peer.sv
// Directed bench for kf8255_mode1_peer; the bench plays the PPI side by hand.
module tb_kf8255_mode1_peer;

  logic       clock = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [2:0] tx_level;
  logic [7:0] ppi_in_data;
  logic       stb_n;
  logic       ibf;
  logic [7:0] ppi_out_data;
  logic       obf_n;
  logic       ack_n;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       timeout;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clock = ~clock;

  kf8255_mode1_peer dut (
    .clock        (clock),
    .reset        (reset),
    .tx_data      (tx_data),
    .tx_valid     (tx_valid),
    .tx_ready     (tx_ready),
    .tx_level     (tx_level),
    .ppi_in_data  (ppi_in_data),
    .stb_n        (stb_n),
    .ibf          (ibf),
    .ppi_out_data (ppi_out_data),
    .obf_n        (obf_n),
    .ack_n        (ack_n),
    .rx_data      (rx_data),
    .rx_valid     (rx_valid),
    .rx_ready     (rx_ready),
    .timeout      (timeout)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  // Waits for a pop of exp, then measures setup (STB# high) and strobe (STB# low) widths.
  task automatic strobe_observe(input logic [7:0] exp, input string tag);
    int k = 0;
    while (ppi_in_data !== exp && k < 64) begin
      step();
      k++;
    end
    check_eq({tag, "_data"}, 32'(ppi_in_data), 32'(exp));
    k = 0;
    while (stb_n === 1'b1 && k < 64) begin
      step();
      k++;
    end
    check_eq({tag, "_setup"}, k, 2);
    k = 0;
    while (stb_n === 1'b0 && k < 64) begin
      step();
      k++;
    end
    check_eq({tag, "_stb_width"}, k, 3);
  endtask

  task automatic ibf_handshake();
    ibf = 1'b1;
    step();
    step();
    ibf = 1'b0;
    step();
    step();
  endtask

  task automatic ack_observe(input logic [7:0] exp, input string tag);
    int k = 0;
    while (ack_n === 1'b1 && k < 64) begin
      step();
      k++;
    end
    k = 0;
    while (ack_n === 1'b0 && k < 64) begin
      step();
      k++;
    end
    check_eq({tag, "_ack_width"}, k, 3);
    check_eq({tag, "_rx_data"}, 32'(rx_data), 32'(exp));
    check_eq({tag, "_rx_valid"}, 32'(rx_valid), 1);
    obf_n = 1'b1;
    step();
  endtask

  task automatic rx_take(input string tag);
    rx_ready = 1'b1;
    step();
    rx_ready = 1'b0;
    check_eq({tag, "_rx_clear"}, 32'(rx_valid), 0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish, expected finish within 1 ms");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [7:0] burst [5];
    int k;
    burst = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};

    reset = 1'b1; tx_data = '0; tx_valid = 1'b0; ibf = 1'b0;
    ppi_out_data = '0; obf_n = 1'b1; rx_ready = 1'b0;
    step();
    step();
    reset = 1'b0;
    check_eq("rst_stb_n", 32'(stb_n), 1);
    check_eq("rst_ack_n", 32'(ack_n), 1);
    check_eq("rst_ppi_in_data", 32'(ppi_in_data), 0);
    check_eq("rst_rx_data", 32'(rx_data), 0);
    check_eq("rst_rx_valid", 32'(rx_valid), 0);
    check_eq("rst_timeout", 32'(timeout), 0);
    check_eq("rst_tx_level", 32'(tx_level), 0);
    check_eq("rst_tx_ready", 32'(tx_ready), 1);

    // Single byte, then a burst pushed while the producer waits on IBF.
    tx_data = 8'h5A; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    strobe_observe(8'h5A, "b5a");
    for (int i = 0; i < 5; i++) begin
      tx_data  = burst[i];
      tx_valid = 1'b1;
      check_eq($sformatf("burst_ready_%0d", i), 32'(tx_ready), (i < 4) ? 1 : 0);
      step();
    end
    tx_valid = 1'b0;
    check_eq("burst_level_full", 32'(tx_level), 4);
    ibf_handshake();
    for (int i = 0; i < 4; i++) begin
      strobe_observe(burst[i], $sformatf("burst_%0d", i));
      ibf_handshake();
    end
    k = 0;
    for (int i = 0; i < 30; i++) begin
      if (stb_n === 1'b0) k++;
      step();
    end
    check_eq("dropped_55_no_stb", k, 0);
    check_eq("burst_level_empty", 32'(tx_level), 0);

    // IBF already high blocks the strobe; then hold IBF low to force a timeout.
    ibf = 1'b1;
    tx_data = 8'h77; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      if (stb_n === 1'b0) k++;
      step();
    end
    check_eq("ibf_block_no_stb", k, 0);
    check_eq("ibf_block_level", 32'(tx_level), 1);
    ibf = 1'b0;
    strobe_observe(8'h77, "b77");
    k = 0;
    while (timeout !== 1'b1 && k < 2000) begin
      step();
      k++;
    end
    check_eq("timeout_cycles", k, 1024);
    step();
    check_eq("timeout_one_pulse", 32'(timeout), 0);
    check_eq("timeout_stb_n", 32'(stb_n), 1);
    tx_data = 8'h88; tx_valid = 1'b1;
    step();
    tx_valid = 1'b0;
    strobe_observe(8'h88, "b88_after_to");
    ibf_handshake();

    // Consumer with backpressure.
    ppi_out_data = 8'hC3; obf_n = 1'b0;
    ack_observe(8'hC3, "rxc3");
    ppi_out_data = 8'h5E; obf_n = 1'b0;
    k = 0;
    for (int i = 0; i < 10; i++) begin
      if (ack_n === 1'b0) k++;
      step();
    end
    check_eq("rx_backpressure_no_ack", k, 0);
    check_eq("rx_backpressure_data", 32'(rx_data), 32'h0C3);
    rx_take("rxc3");
    ack_observe(8'h5E, "rx5e");
    rx_take("rx5e");

    // Concurrent producer and consumer handshakes.
    tx_data = 8'hA5; tx_valid = 1'b1;
    ppi_out_data = 8'h3C; obf_n = 1'b0;
    step();
    tx_valid = 1'b0;
    fork
      begin
        strobe_observe(8'hA5, "conc_tx");
        ibf_handshake();
      end
      begin
        ack_observe(8'h3C, "conc_rx");
        rx_take("conc_rx");
      end
    join

    // Reset while STB# and ACK# are both active.
    tx_data = 8'h99; tx_valid = 1'b1;
    step();
    tx_data = 8'h9A;
    step();
    tx_valid = 1'b0;
    k = 0;
    while (stb_n !== 1'b0 && k < 32) begin
      step();
      k++;
    end
    ppi_out_data = 8'h42; obf_n = 1'b0;
    step();
    check_eq("mid_stb_active", 32'(stb_n), 0);
    check_eq("mid_ack_active", 32'(ack_n), 0);
    check_eq("mid_level", 32'(tx_level), 1);
    reset = 1'b1;
    step();
    check_eq("mid_rst_stb_n", 32'(stb_n), 1);
    check_eq("mid_rst_ack_n", 32'(ack_n), 1);
    check_eq("mid_rst_rx_valid", 32'(rx_valid), 0);
    check_eq("mid_rst_tx_level", 32'(tx_level), 0);
    check_eq("mid_rst_ppi_in_data", 32'(ppi_in_data), 0);
    reset = 1'b0;
    obf_n = 1'b1;
    step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
